// File: rtl/wash_timer_sense.sv
// wash_timer_sense: run-gated cycle/spin timers, debounced hysteretic level flags and valve watchdog; `WASH_TIMER_PAUSE_EN adds a pause input that freezes timers and watchdog
module wash_timer_sense #(
  parameter int CNT_W       = 16,
  parameter int CYCLE_TICKS = 1000,
  parameter int SPIN_TICKS  = 500,
  parameter int LVL_W       = 8,
  parameter int FULL_LEVEL  = 200,
  parameter int EMPTY_LEVEL = 10,
  parameter int HYST        = 8,
  parameter int DEB_CYC     = 4,
  parameter int WD_LIMIT    = 4000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wash_run,
  input  logic             spin_run,
`ifdef WASH_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             fill_on,
  input  logic             drain_on,
  input  logic [LVL_W-1:0] level,
  output logic             cycle_timeout,
  output logic             spin_timeout,
  output logic             filled,
  output logic             drained,
  output logic [1:0]       fault
);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYCLE_TICKS - 1);
  localparam logic [CNT_W-1:0] SPN_LAST = CNT_W'(SPIN_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(WD_LIMIT - 1);
  localparam logic [LVL_W:0] FULL_Q    = (LVL_W+1)'(FULL_LEVEL);
  localparam logic [LVL_W:0] EMPTY_Q   = (LVL_W+1)'(EMPTY_LEVEL);
  localparam logic [LVL_W:0] FULL_REL  = (FULL_LEVEL >= HYST) ? (LVL_W+1)'(FULL_LEVEL - HYST) : '0;
  localparam logic [LVL_W:0] EMPTY_REL = (EMPTY_LEVEL + HYST > (2**LVL_W) - 1) ?
                                         (LVL_W+1)'((2**LVL_W) - 1) : (LVL_W+1)'(EMPTY_LEVEL + HYST);

  typedef enum logic [1:0] {EMPTY, MID, FULL} lvl_e;

  logic             hold;
  logic [CNT_W-1:0] ccnt_q, ccnt_d, scnt_q, scnt_d, dcnt_q, wd_q, base;
  logic             cto_q, cto_d, sto_q, sto_d, pend_q, q_f, q_e, fill_act, drain_act;
  logic [LVL_W:0]   lvl_x;
  logic [1:0]       fault_q;
  lvl_e             state_q;

`ifdef WASH_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign lvl_x     = {1'b0, level};
  assign q_f       = lvl_x >= FULL_Q;
  assign q_e       = lvl_x <= EMPTY_Q;
  assign base      = (dcnt_q != '0 && pend_q == q_f) ? dcnt_q : '0;
  assign fill_act  = fill_on && state_q != FULL;
  assign drain_act = drain_on && state_q != EMPTY;

  // next state of both saturating run timers; a dropped run clears, a pause freezes
  always_comb begin
    ccnt_d = hold ? ccnt_q : (!wash_run ? '0 : (ccnt_q == CYC_LAST ? ccnt_q : ccnt_q + 1'b1));
    cto_d  = hold ? cto_q  : (wash_run && ccnt_q == CYC_LAST);
    scnt_d = hold ? scnt_q : (!spin_run ? '0 : (scnt_q == SPN_LAST ? scnt_q : scnt_q + 1'b1));
    sto_d  = hold ? sto_q  : (spin_run && scnt_q == SPN_LAST);
  end

  // timer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ccnt_q <= '0;
      scnt_q <= '0;
      cto_q  <= 1'b0;
      sto_q  <= 1'b0;
    end else begin
      ccnt_q <= ccnt_d;
      scnt_q <= scnt_d;
      cto_q  <= cto_d;
      sto_q  <= sto_d;
    end
  end

  // level FSM: debounced entry into FULL/EMPTY, immediate hysteretic release to MID
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= MID;
      dcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else if (state_q == FULL) begin
      dcnt_q <= '0;
      if (lvl_x < FULL_REL) state_q <= MID;
    end else if (state_q == EMPTY) begin
      dcnt_q <= '0;
      if (lvl_x > EMPTY_REL) state_q <= MID;
    end else if (q_f || q_e) begin
      if (base == DEB_LAST) begin
        state_q <= q_f ? FULL : EMPTY;
        dcnt_q  <= '0;
      end else begin
        dcnt_q <= base + 1'b1;
        pend_q <= q_f;
      end
    end else begin
      dcnt_q <= '0;
    end
  end

  // valve watchdog and sticky fault code; conflict overrides any earlier watchdog fault
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q    <= '0;
      fault_q <= 2'd0;
    end else begin
      if (!hold) wd_q <= (fill_act || drain_act) ? (wd_q == WD_LAST ? wd_q : wd_q + 1'b1) : '0;
      if (fill_on && drain_on) fault_q <= 2'd3;
      else if (fault_q == 2'd0 && !hold && (fill_act || drain_act) && wd_q == WD_LAST)
        fault_q <= fill_act ? 2'd1 : 2'd2;
    end
  end

  assign cycle_timeout = cto_q;
  assign spin_timeout  = sto_q;
  assign filled        = state_q == FULL;
  assign drained       = state_q == EMPTY;
  assign fault         = fault_q;
endmodule

// File: tb/tb_wash_timer_sense.sv
// tb_wash_timer_sense: directed checks of timers, level flags and watchdog, with table-driven level vectors
module tb_wash_timer_sense;
  logic       clock, reset, wash_run, spin_run, fill_on, drain_on;
  logic [7:0] level;
  logic       cycle_timeout, spin_timeout, filled, drained;
  logic [1:0] fault;
`ifdef WASH_TIMER_PAUSE_EN
  logic       pause;
`endif
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] lvl;
    logic       ef;
    logic       ed;
  } vec_t;
  vec_t tab[15];

  wash_timer_sense dut (
    .clock(clock), .reset(reset), .wash_run(wash_run), .spin_run(spin_run),
`ifdef WASH_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .fill_on(fill_on), .drain_on(drain_on), .level(level),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
    .filled(filled), .drained(drained), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_async_outs", {cycle_timeout, spin_timeout, filled, drained, fault}, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    tab[0]  = '{8'd205, 1'b0, 1'b0};
    tab[1]  = '{8'd205, 1'b0, 1'b0};
    tab[2]  = '{8'd150, 1'b0, 1'b0};
    tab[3]  = '{8'd205, 1'b0, 1'b0};
    tab[4]  = '{8'd205, 1'b0, 1'b0};
    tab[5]  = '{8'd205, 1'b0, 1'b0};
    tab[6]  = '{8'd205, 1'b1, 1'b0};
    tab[7]  = '{8'd193, 1'b1, 1'b0};
    tab[8]  = '{8'd191, 1'b0, 1'b0};
    tab[9]  = '{8'd10,  1'b0, 1'b0};
    tab[10] = '{8'd5,   1'b0, 1'b0};
    tab[11] = '{8'd0,   1'b0, 1'b0};
    tab[12] = '{8'd0,   1'b0, 1'b1};
    tab[13] = '{8'd18,  1'b0, 1'b1};
    tab[14] = '{8'd19,  1'b0, 1'b0};
    reset = 1'b1; wash_run = 1'b0; spin_run = 1'b0; fill_on = 1'b0; drain_on = 1'b0; level = 8'd100;
`ifdef WASH_TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    step(2);
    chk("reset_cto", cycle_timeout, 0);
    chk("reset_sto", spin_timeout, 0);
    chk("reset_filled", filled, 0);
    chk("reset_drained", drained, 0);
    chk("reset_fault", fault, 0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      level = tab[i].lvl;
      step(1);
      chk($sformatf("tab%0d_filled", i), filled, tab[i].ef);
      chk($sformatf("tab%0d_drained", i), drained, tab[i].ed);
    end
    for (int i = 0; i <= 44; i++) begin
      level = (i <= 40) ? 8'(200 - 5 * i) : 8'd0;
      step(1);
      chk($sformatf("ramp_dn%0d_drained", i), drained, i >= 41);
    end
    for (int v = 0; v <= 30; v += 5) begin
      level = 8'(v);
      step(1);
      chk($sformatf("ramp_up%0d_drained", v), drained, v <= 18);
    end
    wash_run = 1'b1; spin_run = 1'b1;
    step(499);
    chk("spin_499", spin_timeout, 0);
    step(1);
    chk("spin_500", spin_timeout, 1);
    step(499);
    chk("cyc_999", cycle_timeout, 0);
    step(1);
    chk("cyc_1000", cycle_timeout, 1);
    step(5);
    chk("cyc_hold", cycle_timeout, 1);
    pulse_reset();
    step(999);
    chk("cyc_post_reset_999", cycle_timeout, 0);
    step(1);
    chk("cyc_post_reset_1000", cycle_timeout, 1);
    wash_run = 1'b0;
    step(1);
    chk("cyc_drop", cycle_timeout, 0);
    wash_run = 1'b1;
    step(600);
    wash_run = 1'b0;
    step(1);
    wash_run = 1'b1;
    step(999);
    chk("cyc_restart_999", cycle_timeout, 0);
    step(1);
    chk("cyc_restart_1000", cycle_timeout, 1);
    wash_run = 1'b0; spin_run = 1'b0;
    step(1);
    chk("spin_drop", spin_timeout, 0);
    level = 8'd0;
    pulse_reset();
    fill_on = 1'b1;
    step(3000);
    fill_on = 1'b0;
    step(1);
    fill_on = 1'b1;
    step(3999);
    chk("wd_fill_3999", fault, 0);
    step(1);
    chk("wd_fill_4000", fault, 1);
    drain_on = 1'b1;
    step(1);
    chk("conflict", fault, 3);
    drain_on = 1'b0; fill_on = 1'b0;
    step(5);
    chk("conflict_sticky", fault, 3);
    level = 8'd100;
    pulse_reset();
    drain_on = 1'b1;
    step(3999);
    chk("wd_drain_3999", fault, 0);
    step(1);
    chk("wd_drain_4000", fault, 2);
    drain_on = 1'b0; fill_on = 1'b1;
    step(4005);
    chk("first_fault_wins", fault, 2);
    drain_on = 1'b1;
    step(1);
    chk("conflict_overrides", fault, 3);
    fill_on = 1'b0; drain_on = 1'b0;
`ifdef WASH_TIMER_PAUSE_EN
    pulse_reset();
    spin_run = 1'b1;
    step(300);
    spin_run = 1'b0; pause = 1'b1;
    step(50);
    chk("pause_sto", spin_timeout, 0);
    spin_run = 1'b1; pause = 1'b0;
    step(199);
    chk("pause_resume_199", spin_timeout, 0);
    step(1);
    chk("pause_resume_200", spin_timeout, 1);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
